// File: rtl/xbus_arbiter_pkg.sv
// rtl/xbus_arbiter_pkg.sv - shared FSM encoding, master indices and default watchdog limit
package xbus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } xbus_state_e;

  localparam int M_IFETCH       = 0;
  localparam int M_DATA         = 1;
  localparam int TO_CYC_DEFAULT = 255;

endpackage

// File: rtl/xbus_arbiter_if.sv
// rtl/xbus_arbiter_if.sv - two master ports plus the shared xbus; slave = arbiter view
interface xbus_arbiter_if #(
  parameter int XADDRW    = 32,
  parameter int XDATAW    = 32,
  parameter int XSLAVE_CH = 4
);
  logic                  m0_req,   m1_req;
  logic [XADDRW-1:0]     m0_addr,  m1_addr;
  logic                  m0_we,    m1_we;
  logic [XDATAW-1:0]     m0_wdata, m1_wdata;
  logic [XDATAW/8-1:0]   m0_be,    m1_be;
  logic                  m0_ack,   m1_ack;
  logic                  m0_err,   m1_err;
  logic [XDATAW-1:0]     m0_rdata, m1_rdata;

  logic                  xbus_as;
  logic                  xbus_we;
  logic [XADDRW-1:0]     xbus_addr;
  logic [XDATAW-1:0]     xbus_wdata;
  logic [XDATAW/8-1:0]   xbus_be;
  logic [XSLAVE_CH-1:0]  xbus_cs;
  logic                  xbus_rdy;
  logic [XDATAW-1:0]     xbus_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata, m0_be,
    input  m1_req, m1_addr, m1_we, m1_wdata, m1_be,
    output m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
    output xbus_as, xbus_we, xbus_addr, xbus_wdata, xbus_be,
    input  xbus_cs, xbus_rdy, xbus_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata, m0_be,
    output m1_req, m1_addr, m1_we, m1_wdata, m1_be,
    input  m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
    input  xbus_as, xbus_we, xbus_addr, xbus_wdata, xbus_be,
    output xbus_cs, xbus_rdy, xbus_rdata
  );

endinterface

// File: rtl/xbus_rr_sel.sv
// rtl/xbus_rr_sel.sv - two-way round-robin grant; contention goes to the master not granted last
module xbus_rr_sel
  import xbus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt           = '0;
    gnt[M_IFETCH] = req[M_IFETCH] & (~req[M_DATA] | last_gnt);
    gnt[M_DATA]   = req[M_DATA] & (~req[M_IFETCH] | ~last_gnt);
  end

endmodule

// File: rtl/xbus_arbiter.sv
// rtl/xbus_arbiter.sv - two-master xbus arbiter, IDLE/BUS/RESP FSM
// Optional BUS watchdog enabled by defining XBUS_TIMEOUT_EN.
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int XADDRW    = 32,
  parameter int XDATAW    = 32,
  parameter int XSLAVE_CH = 4,
  parameter int TO_CYC    = TO_CYC_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  xbus_arbiter_if.slave bus
);

  localparam int BEW = XDATAW / 8;

  xbus_state_e         state_q, state_d;
  logic                last_q, last_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [XADDRW-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [XDATAW-1:0]   wdata_q, wdata_d;
  logic [BEW-1:0]      be_q, be_d;
  logic [XDATAW-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          gnt_w;

`ifdef XBUS_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0]       cnt_q, cnt_d;
`endif

  xbus_rr_sel u_rr_sel (
    .req      ({bus.m1_req, bus.m0_req}),
    .last_gnt (last_q),
    .gnt      (gnt_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef XBUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef XBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef XBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|gnt_w) begin
          state_d = ST_BUS;
          gnt_d   = gnt_w;
          last_d  = gnt_w[M_DATA];
          addr_d  = gnt_w[M_DATA] ? bus.m1_addr  : bus.m0_addr;
          we_d    = gnt_w[M_DATA] ? bus.m1_we    : bus.m0_we;
          wdata_d = gnt_w[M_DATA] ? bus.m1_wdata : bus.m0_wdata;
          be_d    = gnt_w[M_DATA] ? bus.m1_be    : bus.m0_be;
          rdata_d = '0;
          err_d   = 1'b0;
`ifdef XBUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUS: begin
        // An unmapped address wins over rdy: no slave is really answering.
        if (bus.xbus_cs == '0) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (bus.xbus_rdy) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = bus.xbus_rdata;
        end
`ifdef XBUS_TIMEOUT_EN
        else if (cnt_q == CW'(TO_CYC - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.xbus_as    = (state_q == ST_BUS);
    bus.xbus_we    = bus.xbus_as & we_q;
    bus.xbus_addr  = bus.xbus_as ? addr_q  : '0;
    bus.xbus_wdata = bus.xbus_as ? wdata_q : '0;
    bus.xbus_be    = bus.xbus_as ? be_q    : '0;
    bus.m0_ack     = (state_q == ST_RESP) & gnt_q[M_IFETCH];
    bus.m1_ack     = (state_q == ST_RESP) & gnt_q[M_DATA];
    bus.m0_err     = bus.m0_ack & err_q;
    bus.m1_err     = bus.m1_ack & err_q;
    bus.m0_rdata   = bus.m0_ack ? rdata_q : '0;
    bus.m1_rdata   = bus.m1_ack ? rdata_q : '0;
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb/tb_xbus_arbiter.sv - directed vector bench for xbus_arbiter
module tb_xbus_arbiter;

  typedef struct {
    logic        m0r;
    logic        m1r;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        we1;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [3:0]  cs;
    int          waits;
    logic [31:0] rd;
    int          gnt;
    logic        err;
    logic [31:0] erd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbus_arbiter_if #(.XADDRW(32), .XDATAW(32), .XSLAVE_CH(4)) bif ();

  xbus_arbiter #(.XADDRW(32), .XDATAW(32), .XSLAVE_CH(4), .TO_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int total = 0;
  int bad   = 0;
  vec_t vt[9];
  vec_t va, vb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [31:0] xa, xwd;
    logic [3:0]  xbe;
    logic        xwe;
    int          k;
    bit          done;
    xa  = (v.gnt == 1) ? v.a1 : v.a0;
    xwe = (v.gnt == 1) ? v.we1 : 1'b0;
    xwd = (v.gnt == 1) ? v.wd : ~v.wd;
    xbe = (v.gnt == 1) ? v.be : ~v.be;
    @(negedge clk);
    chk({tag, " idle_acks"}, {62'd0, bif.m1_ack, bif.m0_ack}, 64'd0);
    chk({tag, " idle_rdata"}, {bif.m1_rdata, bif.m0_rdata}, 64'd0);
    bif.m0_req = v.m0r;  bif.m0_addr = v.a0;  bif.m0_we = 1'b0;
    bif.m0_wdata = ~v.wd; bif.m0_be = ~v.be;
    bif.m1_req = v.m1r;  bif.m1_addr = v.a1;  bif.m1_we = v.we1;
    bif.m1_wdata = v.wd; bif.m1_be = v.be;
    bif.xbus_cs = v.cs;  bif.xbus_rdy = 1'b0; bif.xbus_rdata = v.rd;
    @(negedge clk);
    k = 0;
    done = 1'b0;
    while (!done) begin
      chk({tag, " as"}, {63'd0, bif.xbus_as}, 64'd1);
      chk({tag, " attr"}, {bif.xbus_addr, xbus_ctl()}, {xa, xwe, xwd[22:0], xbe, 4'd0});
      bif.xbus_rdy = (k == v.waits);
      done = (k == v.waits);
      k++;
      @(negedge clk);
    end
    chk({tag, " resp_as"}, {63'd0, bif.xbus_as}, 64'd0);
    chk({tag, " acks"}, {60'd0, bif.m1_err, bif.m0_err, bif.m1_ack, bif.m0_ack},
        {60'd0, v.err && v.gnt == 1, v.err && v.gnt == 0, v.gnt == 1, v.gnt == 0});
    chk({tag, " rdata"}, {bif.m1_rdata, bif.m0_rdata},
        (v.gnt == 1) ? {v.erd, 32'd0} : {32'd0, v.erd});
    if (v.gnt == 1) bif.m1_req = 1'b0;
    else            bif.m0_req = 1'b0;
    bif.xbus_rdy = 1'b0;
  endtask

  function automatic logic [31:0] xbus_ctl();
    return {bif.xbus_we, bif.xbus_wdata[22:0], bif.xbus_be, 4'd0};
  endfunction

  initial begin
    int ok;
    vt[0] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h11, 4'h3, 4'h1, 1, 32'hA0A00001, 0, 1'b0, 32'hA0A00001};
    vt[1] = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h22, 4'h3, 4'h1, 0, 32'hA0A00002, 1, 1'b0, 32'hA0A00002};
    vt[2] = '{1'b1, 1'b1, 32'h104, 32'h204, 1'b0, 32'h33, 4'h6, 4'h2, 2, 32'hA0A00003, 0, 1'b0, 32'hA0A00003};
    vt[3] = '{1'b1, 1'b1, 32'h108, 32'h208, 1'b0, 32'h44, 4'h9, 4'h1, 0, 32'hA0A00004, 1, 1'b0, 32'hA0A00004};
    vt[4] = '{1'b1, 1'b0, 32'h80000000, 32'h0, 1'b0, 32'h0, 4'hF, 4'b0010, 0, 32'h12345678, 0, 1'b0, 32'h12345678};
    vt[5] = '{1'b0, 1'b1, 32'h0, 32'h10000004, 1'b1, 32'hA5, 4'b0001, 4'b0100, 3, 32'h0, 1, 1'b0, 32'h0};
    vt[6] = '{1'b0, 1'b1, 32'h0, 32'h20000000, 1'b0, 32'h0, 4'hF, 4'b0000, 0, 32'hDEADBEEF, 1, 1'b1, 32'h0};
    vt[7] = '{1'b0, 1'b1, 32'h0, 32'h30000000, 1'b0, 32'h77, 4'hF, 4'b1000, 1, 32'h0BADF00D, 1, 1'b0, 32'h0BADF00D};
    vt[8] = '{1'b1, 1'b1, 32'h40000000, 32'h50000000, 1'b1, 32'h88, 4'h5, 4'h1, 0, 32'h5A5A5A5A, 0, 1'b0, 32'h5A5A5A5A};
    va    = '{1'b1, 1'b1, 32'h600, 32'h700, 1'b0, 32'h99, 4'h1, 4'h1, 0, 32'h00000066, 1, 1'b0, 32'h00000066};
    vb    = '{1'b1, 1'b1, 32'h800, 32'h900, 1'b0, 32'hAA, 4'h2, 4'h1, 0, 32'h00000088, 0, 1'b0, 32'h00000088};

    bif.m0_req = 1'b0; bif.m0_addr = '0; bif.m0_we = 1'b0; bif.m0_wdata = '0; bif.m0_be = '0;
    bif.m1_req = 1'b0; bif.m1_addr = '0; bif.m1_we = 1'b0; bif.m1_wdata = '0; bif.m1_be = '0;
    bif.xbus_cs = '0;  bif.xbus_rdy = 1'b0; bif.xbus_rdata = '0;

    repeat (2) @(negedge clk);
    chk("reset_outs", {58'd0, bif.xbus_as, bif.xbus_we, bif.m1_err, bif.m0_err, bif.m1_ack, bif.m0_ack}, 64'd0);
    chk("reset_bus", {bif.xbus_addr, bif.xbus_wdata}, 64'd0);
    chk("reset_rdata", {bif.m1_rdata, bif.m0_rdata}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run(vt[i], $sformatf("v%0d", i));

    // m1 requests only while m0 owns the bus, then withdraws: no grant, pointer untouched.
    @(negedge clk);
    bif.m0_req = 1'b1; bif.m0_addr = 32'h300; bif.m1_req = 1'b0;
    bif.xbus_cs = 4'h1; bif.xbus_rdy = 1'b0;
    @(negedge clk);
    chk("drop as", {63'd0, bif.xbus_as}, 64'd1);
    chk("drop addr", {32'd0, bif.xbus_addr}, 64'h300);
    bif.m1_req = 1'b1; bif.xbus_rdy = 1'b1; bif.xbus_rdata = 32'h55;
    @(negedge clk);
    chk("drop acks", {62'd0, bif.m1_ack, bif.m0_ack}, 64'd1);
    chk("drop rdata", {32'd0, bif.m0_rdata}, 64'h55);
    bif.m0_req = 1'b0; bif.m1_req = 1'b0; bif.xbus_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop quiet", {62'd0, bif.xbus_as, bif.m1_ack}, 64'd0);
    end
    run(va, "after_drop");

    // Slave never ready.
    @(negedge clk);
    bif.m0_req = 1'b1; bif.m0_addr = 32'h400; bif.xbus_cs = 4'h1; bif.xbus_rdy = 1'b0;
`ifdef XBUS_TIMEOUT_EN
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bif.xbus_as && !bif.m0_ack) ok++;
    end
    chk("to wait", 64'(ok), 64'd8);
    @(negedge clk);
    chk("to resp", {61'd0, bif.xbus_as, bif.m0_err, bif.m0_ack}, 64'd3);
    bif.m0_req = 1'b0;
`else
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bif.xbus_as && !bif.m0_ack && !bif.m0_err) ok++;
    end
    chk("hang wait", 64'(ok), 64'd100);
    @(negedge clk);
    rst_n = 1'b0; bif.m0_req = 1'b0;
    #1 chk("hang rst as", {63'd0, bif.xbus_as}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Reset in the middle of a BUS wait.
    @(negedge clk);
    bif.m1_req = 1'b1; bif.m1_addr = 32'h500; bif.xbus_cs = 4'h1; bif.xbus_rdy = 1'b0;
    @(negedge clk);
    chk("rst bus0", {63'd0, bif.xbus_as}, 64'd1);
    @(negedge clk);
    chk("rst bus1", {63'd0, bif.xbus_as}, 64'd1);
    rst_n = 1'b0;
    #1 chk("rst as", {61'd0, bif.xbus_as, bif.m1_ack, bif.m1_err}, 64'd0);
    bif.m1_req = 1'b0;
    @(negedge clk);
    chk("rst noack", {61'd0, bif.xbus_as, bif.m1_ack, bif.m1_err}, 64'd0);
    rst_n = 1'b1;
    run(vb, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xbus_arbiter.md
XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 SHALL have parameter XADDRW, default 32: address width of both master ports and the bus.
REQ-002 SHALL have parameter XDATAW, default 32: data width.
REQ-003 SHALL have parameter XSLAVE_CH, default 4: chip-select width from the bus decoder.
REQ-004 SHALL have parameter TO_CYC, default 255: watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports m0_req/m1_req, input, 1: master request (m0 is instruction fetch, m1 is data).
REQ-008 SHALL have ports mN_addr (XADDRW), mN_we (1), mN_wdata (XDATAW), mN_be (XDATAW/8), all inputs: request attributes, held stable while mN_req is high.
REQ-009 SHALL have ports mN_ack, mN_err, outputs, 1: one-cycle completion and error pulses.
REQ-010 SHALL have ports mN_rdata, output, XDATAW: read data, valid only while mN_ack is high.
REQ-011 SHALL have ports xbus_as, xbus_we (1), xbus_addr (XADDRW), xbus_wdata (XDATAW), xbus_be (XDATAW/8), all outputs: bus request.
REQ-012 SHALL have ports xbus_cs (XSLAVE_CH), xbus_rdy (1), xbus_rdata (XDATAW), all inputs: decoder select, slave ready and slave read data.

Function
REQ-013 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE.
REQ-014 In IDLE with any request, SHALL latch the winner's attributes and go to BUS on the next edge.
REQ-015 SHALL drive xbus_as=1 with the latched attributes for every cycle in BUS, and xbus_as=0 in all other states.
REQ-016 In BUS, if xbus_rdy=1, SHALL capture xbus_rdata, record no error and go to RESP.
REQ-017 In BUS, if xbus_cs is all zero (unmapped address), SHALL go to RESP with the error flag set, ignoring xbus_rdy.
REQ-018 In RESP, SHALL pulse the granted master's mN_ack for exactly one cycle (plus mN_err if the error flag is set), then return to IDLE.
REQ-019 Latency: request seen in IDLE at cycle 0, xbus_as high at cycle 1, ack in the cycle after the cycle rdy is sampled; a zero-wait slave gives ack at cycle 2.
REQ-020 Arbitration SHALL be round-robin: when both masters request, grant the master not granted last; a single requester is always granted.
REQ-021 The last-grant pointer SHALL update only on a grant.
REQ-022 A master whose request drops while not granted SHALL lose its place with no side effects.
REQ-023 A granted transaction SHALL always run to RESP; mN_req is not re-sampled mid-transaction.
REQ-024 Masters SHALL deassert req in the cycle after ack; a req still high in IDLE after RESP is treated as a new request.
REQ-025 mN_rdata SHALL be zero while mN_ack is low.

Reset
REQ-026 While rst_n=0, SHALL hold state IDLE, last-grant pointer m1 (so m0 wins first), all outputs 0, latched attributes 0 and watchdog count 0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack; after release the block starts in IDLE.

Configuration
REQ-028 With XBUS_TIMEOUT_EN defined, SHALL count cycles spent in BUS.
REQ-029 With XBUS_TIMEOUT_EN defined, reaching TO_CYC with xbus_rdy still low SHALL go to RESP with the error flag set; the count clears on entering BUS.
REQ-030 With XBUS_TIMEOUT_EN undefined, there SHALL be no counter, and BUS waits for xbus_rdy indefinitely.

Structure
REQ-031 The shared config package SHALL hold the FSM state encoding, master index constants (M_IFETCH=0, M_DATA=1) and the default TO_CYC.
REQ-032 Round-robin grant selection SHALL be one sub-module, xbus_rr_sel: inputs are the 2 requests and the last-grant pointer; output is the one-hot grant.
REQ-033 Address decoding SHALL stay external; xbus_cs is only consumed.

Verification
REQ-034 Idle m0 read of 0x80000000, cs=0010, slave rdy after 0 waits, rdata=0x12345678 -> m0_ack at cycle 2 with m0_rdata=0x12345678 and m0_err=0.
REQ-035 m0 and m1 request together for 4 back-to-back transactions -> grant order m0, m1, m0, m1.
REQ-036 m1 write to 0x10000004, wdata=0xA5, be=0001, rdy after 3 waits -> xbus_as high for 4 cycles with stable attributes, then one m1_ack pulse.
REQ-037 m1 read of 0x20000000 with cs=0000 -> m1_ack and m1_err pulse together at cycle 2, m1_rdata=0.
REQ-038 XBUS_TIMEOUT_EN defined, TO_CYC=8, slave never ready -> m0_err+ack after 8 BUS cycles; undefined -> xbus_as stays high for 100 cycles with no ack.
REQ-039 rst_n pulled low at cycle 1 of a BUS wait -> xbus_as=0 immediately, no ack; next request is served normally with m0 first.
